// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared counter encodings, default table size, counter step helper
package branch_predictor_pkg;

  localparam int BP_ENTRIES = 16;

  typedef enum logic [1:0] {
    BP_SNT = 2'b00,
    BP_WNT = 2'b01,
    BP_WT  = 2'b10,
    BP_ST  = 2'b11
  } bp_ctr_t;

  function automatic bp_ctr_t ctr_next(input bp_ctr_t c, input logic taken);
    if (taken) return (c == BP_ST) ? BP_ST : bp_ctr_t'(c + 2'd1);
    return (c == BP_SNT) ? BP_SNT : bp_ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/branch_predictor_bp_table.sv
// rtl/branch_predictor_bp_table.sv - predictor storage: two async read ports, one sync write port
// Valid bits and counters reset asynchronously; tag and target arrays are left unreset.
module bp_table
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES,
  parameter int IDX_W   = 4,
  parameter int TAG_W   = 26,
  parameter int PC_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] lk_idx,
  output logic             lk_valid,
  output logic [TAG_W-1:0] lk_tag,
  output logic [PC_W-1:0]  lk_target,
  output bp_ctr_t          lk_ctr,
  input  logic [IDX_W-1:0] ex_idx,
  output logic             ex_valid,
  output logic [TAG_W-1:0] ex_tag,
  output logic [PC_W-1:0]  ex_target,
  output bp_ctr_t          ex_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [PC_W-1:0]  wr_target,
  input  bp_ctr_t          wr_ctr
);

  logic [ENTRIES-1:0] valid;
  bp_ctr_t            ctr    [ENTRIES];
  logic [TAG_W-1:0]   tag    [ENTRIES];
  logic [PC_W-1:0]    target [ENTRIES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= BP_WNT;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
      ctr[wr_idx]   <= wr_ctr;
    end
  end

  // Gate with rst so a write coinciding with reset leaves no partial state.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      tag[wr_idx]    <= wr_tag;
      target[wr_idx] <= wr_target;
    end
  end

  assign lk_valid  = valid[lk_idx];
  assign lk_tag    = tag[lk_idx];
  assign lk_target = target[lk_idx];
  assign lk_ctr    = ctr[lk_idx];
  assign ex_valid  = valid[ex_idx];
  assign ex_tag    = tag[ex_idx];
  assign ex_target = target[ex_idx];
  assign ex_ctr    = ctr[ex_idx];

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters, mispredict flush and redirect
// Optional statistics counters are enabled by defining BP_STATS_EN.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES,
  parameter int PC_W    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            ex_pred_taken,
  input  logic [PC_W-1:0] ex_pred_target,
  input  logic            ex_taken,
  input  logic [PC_W-1:0] ex_target,
  input  logic            ex_stall,
  output logic            mispredict,
  output logic [PC_W-1:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic             lk_valid, tb_ex_valid;
  logic [TAG_W-1:0] lk_tag, tb_ex_tag;
  logic [PC_W-1:0]  lk_target, tb_ex_target;
  bp_ctr_t          lk_ctr, tb_ex_ctr;
  logic             wr_en;
  logic [PC_W-1:0]  wr_target;
  bp_ctr_t          wr_ctr;
  logic             lk_hit, ex_hit, upd, mp_cond;
  logic [PC_W-1:0]  correct_pc;

  bp_table #(
    .ENTRIES(ENTRIES), .IDX_W(IDX_W), .TAG_W(TAG_W), .PC_W(PC_W)
  ) u_table (
    .clk      (clk),
    .rst      (rst),
    .lk_idx   (if_pc[IDX_W+1:2]),
    .lk_valid (lk_valid),
    .lk_tag   (lk_tag),
    .lk_target(lk_target),
    .lk_ctr   (lk_ctr),
    .ex_idx   (ex_pc[IDX_W+1:2]),
    .ex_valid (tb_ex_valid),
    .ex_tag   (tb_ex_tag),
    .ex_target(tb_ex_target),
    .ex_ctr   (tb_ex_ctr),
    .wr_en    (wr_en),
    .wr_idx   (ex_pc[IDX_W+1:2]),
    .wr_tag   (ex_pc[PC_W-1:IDX_W+2]),
    .wr_target(wr_target),
    .wr_ctr   (wr_ctr)
  );

  assign lk_hit      = lk_valid && (lk_tag == if_pc[PC_W-1:IDX_W+2]);
  assign pred_taken  = lk_hit && lk_ctr[1];
  assign pred_target = pred_taken ? lk_target : '0;

  assign upd    = ex_valid && !ex_stall;
  assign ex_hit = tb_ex_valid && (tb_ex_tag == ex_pc[PC_W-1:IDX_W+2]);

  // Misses that resolve not-taken never allocate, so they cannot evict a useful entry.
  always_comb begin
    wr_en     = upd && (ex_hit || ex_taken);
    wr_ctr    = ex_hit ? ctr_next(tb_ex_ctr, ex_taken) : BP_WT;
    wr_target = ex_taken ? ex_target : tb_ex_target;
  end

  assign mp_cond = upd && ((ex_taken != ex_pred_taken) ||
                           (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)));
  assign correct_pc = ex_taken ? ex_target : ex_pc + PC_W'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      mispredict <= mp_cond;
      if (mp_cond) redirect_pc <= correct_pc;
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (upd && stat_branches != '1) stat_branches <= stat_branches + 32'd1;
      if (mp_cond && stat_mispredicts != '1) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

  logic unused_bits;
  assign unused_bits = ^{if_pc[1:0], ex_pc[1:0], lk_ctr[0]};

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed vector table, corner sequences and randomized model check
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_stall;
  logic        mispredict;
  logic [31:0] redirect_pc;

  int errors = 0;
  int checks = 0;

  branch_predictor #(.ENTRIES(16), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_stall(ex_stall), .mispredict(mispredict), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic [31:0] pc, input logic pt, input logic [31:0] ptg,
                          input logic t, input logic [31:0] tg, input logic st);
    ex_valid = v; ex_pc = pc; ex_pred_taken = pt; ex_pred_target = ptg;
    ex_taken = t; ex_target = tg; ex_stall = st;
  endtask

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptg;
    logic        t;
    logic [31:0] tg;
    logic        st;
    logic [31:0] look;
    logic        e_pt;
    logic [31:0] e_ptg;
    logic        e_mp;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[$];

  // Reference model: one record per table slot, plain integers for the counter.
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_ctr[i] = 1;
    end
  endtask

  task automatic m_predict(input logic [31:0] pc, output logic t, output logic [31:0] tg);
    int i = m_idx(pc);
    t  = m_valid[i] && m_tag[i] == (pc >> 6) && m_ctr[i] >= 2;
    tg = t ? m_tgt[i] : 32'h0;
  endtask

  task automatic m_update(input logic [31:0] pc, input logic t, input logic [31:0] tg);
    int i = m_idx(pc);
    if (m_valid[i] && m_tag[i] == (pc >> 6)) begin
      m_ctr[i] = t ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
      if (t) m_tgt[i] = tg;
    end else if (t) begin
      m_valid[i] = 1; m_tag[i] = pc >> 6; m_tgt[i] = tg; m_ctr[i] = 2;
    end
  endtask

  initial begin
    logic        e_t, e_mp;
    logic [31:0] e_tg, e_rd;

    rst = 1'b1; if_pc = 32'h100;
    drive_ex(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("reset_mispredict", {31'b0, mispredict}, 0);
    check("reset_redirect", redirect_pc, 0);
    check("reset_pred_taken", {31'b0, pred_taken}, 0);
    check("reset_pred_target", pred_target, 0);

    //          v  pc            pt ptg        t  tg         st look          ept eptg       emp erd
    vecs.push_back('{0, 32'h0,        0, 32'h0,   0, 32'h0,   0, 32'h100,      0, 32'h0,   0, 32'h0});
    vecs.push_back('{1, 32'h100,      0, 32'h0,   1, 32'h200, 0, 32'h100,      1, 32'h200, 1, 32'h200});
    vecs.push_back('{1, 32'h100,      1, 32'h200, 1, 32'h200, 0, 32'h100,      1, 32'h200, 0, 32'h0});
    vecs.push_back('{1, 32'h100,      1, 32'h200, 1, 32'h200, 0, 32'h100,      1, 32'h200, 0, 32'h0});
    vecs.push_back('{1, 32'h100,      1, 32'h200, 1, 32'h200, 0, 32'h100,      1, 32'h200, 0, 32'h0});
    vecs.push_back('{1, 32'h100,      1, 32'h200, 0, 32'h0,   0, 32'h100,      1, 32'h200, 1, 32'h104});
    vecs.push_back('{0, 32'h0,        0, 32'h0,   0, 32'h0,   0, 32'h100,      1, 32'h200, 0, 32'h0});
    vecs.push_back('{1, 32'h100,      1, 32'h200, 0, 32'h0,   0, 32'h100,      0, 32'h0,   1, 32'h104});
    vecs.push_back('{1, 32'h100,      0, 32'h0,   0, 32'h0,   0, 32'h100,      0, 32'h0,   0, 32'h0});
    vecs.push_back('{1, 32'h100,      1, 32'h300, 1, 32'h200, 0, 32'h100,      0, 32'h0,   1, 32'h200});
    vecs.push_back('{1, 32'h100,      0, 32'h0,   1, 32'h240, 0, 32'h100,      1, 32'h240, 1, 32'h240});
    vecs.push_back('{1, 32'h100,      1, 32'h240, 0, 32'h0,   1, 32'h100,      1, 32'h240, 0, 32'h0});
    vecs.push_back('{1, 32'h140,      0, 32'h0,   0, 32'h0,   0, 32'h100,      1, 32'h240, 0, 32'h0});
    vecs.push_back('{1, 32'h140,      0, 32'h0,   1, 32'h500, 0, 32'h100,      0, 32'h0,   1, 32'h500});
    vecs.push_back('{0, 32'h0,        0, 32'h0,   0, 32'h0,   0, 32'h140,      1, 32'h500, 0, 32'h0});
    vecs.push_back('{1, 32'hFFFFFFFC, 1, 32'h8,   0, 32'h0,   0, 32'hFFFFFFFC, 0, 32'h0,   1, 32'h0});

    foreach (vecs[n]) begin
      drive_ex(vecs[n].v, vecs[n].pc, vecs[n].pt, vecs[n].ptg, vecs[n].t, vecs[n].tg, vecs[n].st);
      tick();
      ex_valid = 1'b0;
      if_pc = vecs[n].look;
      #1;
      check($sformatf("vec%0d_pred_taken", n), {31'b0, pred_taken}, {31'b0, vecs[n].e_pt});
      check($sformatf("vec%0d_pred_target", n), pred_target, vecs[n].e_ptg);
      check($sformatf("vec%0d_mispredict", n), {31'b0, mispredict}, {31'b0, vecs[n].e_mp});
      if (vecs[n].e_mp) check($sformatf("vec%0d_redirect", n), redirect_pc, vecs[n].e_rd);
    end

    // Lookup and update to the same slot in one cycle sees the old entry.
    drive_ex(1, 32'h140, 1, 32'h500, 0, 32'h0, 0);
    if_pc = 32'h140;
    #1;
    check("nobypass_pre_taken", {31'b0, pred_taken}, 1);
    check("nobypass_pre_target", pred_target, 32'h500);
    tick();
    ex_valid = 1'b0;
    #1;
    check("nobypass_post_taken", {31'b0, pred_taken}, 0);
    check("nobypass_mispredict", {31'b0, mispredict}, 1);
    check("nobypass_redirect", redirect_pc, 32'h144);

    // Reset held across an update edge: nothing is written.
    drive_ex(1, 32'h1C4, 0, 32'h0, 1, 32'h800, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ex_valid = 1'b0;
    if_pc = 32'h1C4;
    #1;
    check("rstmid_pred_new", {31'b0, pred_taken}, 0);
    check("rstmid_mispredict", {31'b0, mispredict}, 0);
    check("rstmid_redirect", redirect_pc, 0);
    if_pc = 32'h140;
    #1;
    check("rstmid_pred_old", {31'b0, pred_taken}, 0);

    m_reset();
    for (int c = 0; c < 400; c++) begin
      logic [31:0] pc, tg, ptg;
      logic        t, pt, st, mt;
      logic [31:0] mtg;
      pc = 32'h1000 + ($urandom_range(0, 3) << 6) + ($urandom_range(0, 3) << 2);
      if ($urandom_range(0, 15) == 0) pc = $urandom() & 32'hFFFFFFFC;
      t  = 1'($urandom_range(0, 1));
      tg = 32'h4000 + ($urandom_range(0, 3) << 4);
      m_predict(pc, mt, mtg);
      if ($urandom_range(0, 3) != 0) begin pt = mt; ptg = mtg; end
      else begin pt = 1'($urandom_range(0, 1)); ptg = 32'h4000 + ($urandom_range(0, 3) << 4); end
      st = ($urandom_range(0, 7) == 0);
      drive_ex(1'($urandom_range(0, 4) != 0), pc, pt, ptg, t, tg, st);
      if_pc = 32'h1000 + ($urandom_range(0, 3) << 6) + ($urandom_range(0, 3) << 2);
      #1;
      m_predict(if_pc, e_t, e_tg);
      check("rand_pred_taken", {31'b0, pred_taken}, {31'b0, e_t});
      check("rand_pred_target", pred_target, e_tg);
      e_mp = ex_valid && !ex_stall && ((t != pt) || (t && pt && tg != ptg));
      e_rd = t ? tg : pc + 32'd4;
      if (ex_valid && !ex_stall) m_update(pc, t, tg);
      tick();
      check("rand_mispredict", {31'b0, mispredict}, {31'b0, e_mp});
      if (e_mp) check("rand_redirect", redirect_pc, e_rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
